rv32i_operand_stage: RTL and testbench
======================================

// Module: rv32i_operand_stage
// PURPOSE
// - ID/EX boundary stage directly upstream of the ALU. Accepts one decoded instruction per cycle.
// - Resolves rs1/rs2 with forwarding, selects the ALU operands, encodes the 4-bit ALU op,
//   detects load-use hazards and registers everything into a valid/ready pipeline register.
// - Registered outputs drive the ALU a/b/op inputs and the rest of the EX stage.
// PARAMETERS
// - XLEN  32  datapath width; only 32 is supported.
// PORTS
// - clk           in   1   clock; all state on rising edge
// - rst_n         in   1   reset, asynchronous, active-low
// - flush         in   1   kill the held instruction and any incoming one (branch/trap redirect)
// - in_valid      in   1   decoded instruction present
// - in_ready      out  1   stage accepts in_* this cycle
// - in_pc         in   32  instruction PC
// - in_opcode     in   7   inst[6:0]
// - in_funct3     in   3   inst[14:12]
// - in_funct7b5   in   1   inst[30]
// - in_rs1_addr   in   5   source register 1 index
// - in_rs2_addr   in   5   source register 2 index
// - in_rd_addr    in   5   destination register index
// - in_rs1_data   in   32  register-file read data for rs1
// - in_rs2_data   in   32  register-file read data for rs2
// - in_imm        in   32  sign-extended immediate produced by the decoder
// - fwd1_valid/fwd1_we/fwd1_is_load  in  1 each   nearer producer (EX), valid, writes rd, is a load
// - fwd1_rd       in   5   EX producer destination register
// - fwd1_data     in   32  EX producer result
// - fwd2_valid/fwd2_we  in  1 each   farther producer (MEM/WB), valid and writes rd
// - fwd2_rd       in   5   MEM/WB producer destination register
// - fwd2_data     in   32  MEM/WB producer result
// - out_valid     out  1   registered instruction valid
// - out_ready     in   1   downstream accepts
// - out_alu_op    out  4   ALU op code
// - out_alu_a     out  32  ALU operand a
// - out_alu_b     out  32  ALU operand b
// - out_rs2_data  out  32  forwarded rs2 (store data, branch compare)
// - out_pc        out  32  instruction PC
// - out_funct3    out  3   forwarded funct3
// - out_rd_addr   out  5   destination register
// - out_rd_we     out  1   writes rd; forced 0 when rd==0
// - out_is_load   out  1   LOAD opcode
// - out_illegal   out  1   unsupported opcode
// BEHAVIOUR
// - Reset: out_valid=0; all other outputs 0. in_ready is combinational and reflects the reset state.
// - ALU op codes:
//   - ADD=0000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, OR=0110, AND=0111,
//     SUB=1000, SRA=1101.
// - Decode, by opcode:
//   - OP 0110011: op={funct7b5,funct3}; a=rs1, b=rs2.
//   - OP-IMM 0010011: op={funct3==101 & funct7b5, funct3}; a=rs1, b=imm.
//   - LOAD 0000011 and STORE 0100011: ADD; a=rs1, b=imm. STORE sets rd_we=0.
//   - LUI 0110111: ADD; a=0, b=imm.
//   - AUIPC 0010111: ADD; a=pc, b=imm.
//   - JAL 1101111 and JALR 1100111: ADD; a=pc, b=4 (link value).
//   - BRANCH 1100011: SUB; a=rs1, b=rs2; rd_we=0.
//   - Any other opcode: illegal=1, ADD, rd_we=0, a=b=0.
// - Source use:
//   - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
//   - rs2 is used by OP, STORE, BRANCH.
// - Forwarding, per source:
//   - Index 0 always yields 0.
//   - Otherwise fwd1 (valid & we & rd match) has priority, then fwd2, then regfile data.
//   - Load-use case: fwd1_is_load data is never forwarded.
// - Load-use stall:
//   - Condition: in_valid & fwd1_valid & fwd1_we & fwd1_is_load & fwd1_rd!=0 &
//     a used source matches fwd1_rd.
//   - While asserted, in_ready=0.
// - Handshake:
//   - in_ready = (!out_valid | out_ready) & !stall, or 1 when flush is asserted.
//   - Transfer when in_valid & in_ready.
//   - On a transfer, capture all outputs and set out_valid=1.
//   - If out_valid & out_ready and there is no transfer, out_valid<=0 (bubble).
//   - If out_valid & !out_ready, all outputs hold stable.
// - Flush: highest priority. Next cycle out_valid=0; the incoming instruction is accepted
//   and discarded. Data registers may keep stale values.
// - Latency: 1 cycle in->out. Throughput: 1 per cycle when out_ready is held high.
// - Reset mid-operation: out_valid clears immediately; no instruction survives.
// TESTING
// - ADD x3,x1,x2; rs1=5, rs2=7, no fwd -> next cycle op=0000, a=5, b=7, rd_we=1.
// - SUB (f7b5=1,f3=000) and SRAI (OP-IMM,f3=101,f7b5=1) -> op 1000 and 1101;
//   ADDI with inst[30]=1 -> 0000.
// - rs1=x4, fwd1 rd=4 data=0xAA, fwd2 rd=4 data=0xBB, regfile 0xCC -> a=0xAA;
//   drop fwd1 -> 0xBB; rs1=x0 -> 0.
// - fwd1 load rd=6, incoming OP uses x6 -> in_ready=0 for that cycle;
//   out_valid drops after out_ready; issues once fwd1 clears.
// - out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; resume without loss.
// - flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle;
//   async rst_n low mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/rv32i_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module     : rv32i_operand_stage_if
// Description: Decoded-instruction, forwarding and EX-side bundle for the
//              ID/EX operand stage.
// Revision   : 1.0
// ============================================================================
interface rv32i_operand_stage_if #(
    parameter int XLEN = 32
);
    logic            flush;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [6:0]      in_opcode;
    logic [2:0]      in_funct3;
    logic            in_funct7b5;
    logic [4:0]      in_rs1_addr;
    logic [4:0]      in_rs2_addr;
    logic [4:0]      in_rd_addr;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;

    logic            fwd1_valid;
    logic            fwd1_we;
    logic            fwd1_is_load;
    logic [4:0]      fwd1_rd;
    logic [XLEN-1:0] fwd1_data;
    logic            fwd2_valid;
    logic            fwd2_we;
    logic [4:0]      fwd2_rd;
    logic [XLEN-1:0] fwd2_data;

    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_alu_op;
    logic [XLEN-1:0] out_alu_a;
    logic [XLEN-1:0] out_alu_b;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_pc;
    logic [2:0]      out_funct3;
    logic [4:0]      out_rd_addr;
    logic            out_rd_we;
    logic            out_is_load;
    logic            out_illegal;

    // Upstream decoder, hazard sources and downstream EX stage.
    modport master (
        output flush, in_valid, in_pc, in_opcode, in_funct3, in_funct7b5,
               in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_data, in_rs2_data, in_imm,
               fwd1_valid, fwd1_we, fwd1_is_load, fwd1_rd, fwd1_data,
               fwd2_valid, fwd2_we, fwd2_rd, fwd2_data, out_ready,
        input  in_ready, out_valid, out_alu_op, out_alu_a, out_alu_b, out_rs2_data,
               out_pc, out_funct3, out_rd_addr, out_rd_we, out_is_load, out_illegal
    );

    // The operand stage itself.
    modport slave (
        input  flush, in_valid, in_pc, in_opcode, in_funct3, in_funct7b5,
               in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_data, in_rs2_data, in_imm,
               fwd1_valid, fwd1_we, fwd1_is_load, fwd1_rd, fwd1_data,
               fwd2_valid, fwd2_we, fwd2_rd, fwd2_data, out_ready,
        output in_ready, out_valid, out_alu_op, out_alu_a, out_alu_b, out_rs2_data,
               out_pc, out_funct3, out_rd_addr, out_rd_we, out_is_load, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/rv32i_operand_stage.sv
`default_nettype none
// ============================================================================
// Module     : rv32i_operand_stage
// Description: RV32I ID/EX stage: forwarding, ALU operand/op selection,
//              load-use stall and a valid/ready output register.
// Revision   : 1.0
// ============================================================================
module rv32i_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rv32i_operand_stage_if.slave bus
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b1000;

    // A pending load in EX is never a legal forwarding source; the stall covers it.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_data,
        input logic            f1_hit,
        input logic [4:0]      f1_rd,
        input logic [XLEN-1:0] f1_data,
        input logic            f2_hit,
        input logic [4:0]      f2_rd,
        input logic [XLEN-1:0] f2_data
    );
        logic [XLEN-1:0] r;
        if (addr == 5'd0)                     r = '0;
        else if (f1_hit && (f1_rd == addr))   r = f1_data;
        else if (f2_hit && (f2_rd == addr))   r = f2_data;
        else                                  r = rf_data;
        return r;
    endfunction

    logic            w_f1_fwd_ok;
    logic            w_f2_fwd_ok;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

    assign w_f1_fwd_ok = bus.fwd1_valid & bus.fwd1_we & ~bus.fwd1_is_load;
    assign w_f2_fwd_ok = bus.fwd2_valid & bus.fwd2_we;

    assign w_rs1_val = fwd_sel(bus.in_rs1_addr, bus.in_rs1_data,
                               w_f1_fwd_ok, bus.fwd1_rd, bus.fwd1_data,
                               w_f2_fwd_ok, bus.fwd2_rd, bus.fwd2_data);
    assign w_rs2_val = fwd_sel(bus.in_rs2_addr, bus.in_rs2_data,
                               w_f1_fwd_ok, bus.fwd1_rd, bus.fwd1_data,
                               w_f2_fwd_ok, bus.fwd2_rd, bus.fwd2_data);

    logic [3:0]      w_alu_op;
    logic [XLEN-1:0] w_alu_a;
    logic [XLEN-1:0] w_alu_b;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_we;
    logic            w_is_load;
    logic            w_illegal;

    always_comb begin
        w_alu_op  = c_ALU_ADD;
        w_alu_a   = '0;
        w_alu_b   = '0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_we      = 1'b0;
        w_is_load = 1'b0;
        w_illegal = 1'b0;
        case (bus.in_opcode)
            c_OPC_OP: begin
                w_alu_op  = {bus.in_funct7b5, bus.in_funct3};
                w_alu_a   = w_rs1_val;
                w_alu_b   = w_rs2_val;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_we      = 1'b1;
            end
            c_OPC_OPIMM: begin
                // inst[30] is an immediate bit except for SRAI.
                w_alu_op  = {(bus.in_funct3 == 3'b101) & bus.in_funct7b5, bus.in_funct3};
                w_alu_a   = w_rs1_val;
                w_alu_b   = bus.in_imm;
                w_use_rs1 = 1'b1;
                w_we      = 1'b1;
            end
            c_OPC_LOAD: begin
                w_alu_a   = w_rs1_val;
                w_alu_b   = bus.in_imm;
                w_use_rs1 = 1'b1;
                w_we      = 1'b1;
                w_is_load = 1'b1;
            end
            c_OPC_STORE: begin
                w_alu_a   = w_rs1_val;
                w_alu_b   = bus.in_imm;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            c_OPC_LUI: begin
                w_alu_b   = bus.in_imm;
                w_we      = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_alu_a   = bus.in_pc;
                w_alu_b   = bus.in_imm;
                w_we      = 1'b1;
            end
            c_OPC_JAL: begin
                w_alu_a   = bus.in_pc;
                w_alu_b   = XLEN'(4);
                w_we      = 1'b1;
            end
            c_OPC_JALR: begin
                w_alu_a   = bus.in_pc;
                w_alu_b   = XLEN'(4);
                w_use_rs1 = 1'b1;
                w_we      = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_alu_op  = c_ALU_SUB;
                w_alu_a   = w_rs1_val;
                w_alu_b   = w_rs2_val;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    logic w_stall;
    logic w_in_ready;
    logic w_xfer;

    assign w_stall = bus.in_valid & bus.fwd1_valid & bus.fwd1_we & bus.fwd1_is_load &
                     (bus.fwd1_rd != 5'd0) &
                     ((w_use_rs1 & (bus.in_rs1_addr == bus.fwd1_rd)) |
                      (w_use_rs2 & (bus.in_rs2_addr == bus.fwd1_rd)));

    logic            valid_q;
    logic [3:0]      alu_op_q;
    logic [XLEN-1:0] alu_a_q;
    logic [XLEN-1:0] alu_b_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] pc_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_addr_q;
    logic            rd_we_q;
    logic            is_load_q;
    logic            illegal_q;

    assign w_in_ready = bus.flush | ((~valid_q | bus.out_ready) & ~w_stall);
    assign w_xfer     = bus.in_valid & w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            rs2_data_q <= '0;
            pc_q       <= '0;
            funct3_q   <= '0;
            rd_addr_q  <= '0;
            rd_we_q    <= 1'b0;
            is_load_q  <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (bus.flush) begin
            valid_q    <= 1'b0;
        end else if (w_xfer) begin
            valid_q    <= 1'b1;
            alu_op_q   <= w_alu_op;
            alu_a_q    <= w_alu_a;
            alu_b_q    <= w_alu_b;
            rs2_data_q <= w_rs2_val;
            pc_q       <= bus.in_pc;
            funct3_q   <= bus.in_funct3;
            rd_addr_q  <= bus.in_rd_addr;
            rd_we_q    <= w_we & (bus.in_rd_addr != 5'd0);
            is_load_q  <= w_is_load;
            illegal_q  <= w_illegal;
        end else if (bus.out_ready) begin
            valid_q    <= 1'b0;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = valid_q;
    assign bus.out_alu_op   = alu_op_q;
    assign bus.out_alu_a    = alu_a_q;
    assign bus.out_alu_b    = alu_b_q;
    assign bus.out_rs2_data = rs2_data_q;
    assign bus.out_pc       = pc_q;
    assign bus.out_funct3   = funct3_q;
    assign bus.out_rd_addr  = rd_addr_q;
    assign bus.out_rd_we    = rd_we_q;
    assign bus.out_is_load  = is_load_q;
    assign bus.out_illegal  = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_operand_stage.sv
`default_nettype none
// ============================================================================
// Module     : tb_rv32i_operand_stage
// Description: Directed vector table plus stall/backpressure/flush/reset
//              sequences for rv32i_operand_stage.
// Revision   : 1.0
// ============================================================================
module tb_rv32i_operand_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rv32i_operand_stage_if ifc ();

    rv32i_operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;   logic [6:0] opc;  logic [2:0] f3;  logic f7;
        logic [4:0]  rs1;  logic [4:0] rs2;  logic [4:0] rd;
        logic [31:0] d1;   logic [31:0] d2;  logic [31:0] imm;
        logic        f1v;  logic f1w;  logic f1l;  logic [4:0] f1rd;  logic [31:0] f1d;
        logic        f2v;  logic f2w;  logic [4:0] f2rd;  logic [31:0] f2d;
        logic [3:0]  e_op; logic [31:0] e_a;  logic [31:0] e_b;  logic [31:0] e_rs2;
        logic        e_we; logic e_ld; logic e_ill;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ifc.flush = 0; ifc.in_valid = 0; ifc.in_pc = 0; ifc.in_opcode = 0;
        ifc.in_funct3 = 0; ifc.in_funct7b5 = 0; ifc.in_rs1_addr = 0; ifc.in_rs2_addr = 0;
        ifc.in_rd_addr = 0; ifc.in_rs1_data = 0; ifc.in_rs2_data = 0; ifc.in_imm = 0;
        ifc.fwd1_valid = 0; ifc.fwd1_we = 0; ifc.fwd1_is_load = 0; ifc.fwd1_rd = 0;
        ifc.fwd1_data = 0; ifc.fwd2_valid = 0; ifc.fwd2_we = 0; ifc.fwd2_rd = 0;
        ifc.fwd2_data = 0;
    endtask

    task automatic drive_vec(input vec_t v);
        ifc.in_valid = 1; ifc.in_pc = v.pc; ifc.in_opcode = v.opc; ifc.in_funct3 = v.f3;
        ifc.in_funct7b5 = v.f7; ifc.in_rs1_addr = v.rs1; ifc.in_rs2_addr = v.rs2;
        ifc.in_rd_addr = v.rd; ifc.in_rs1_data = v.d1; ifc.in_rs2_data = v.d2;
        ifc.in_imm = v.imm; ifc.fwd1_valid = v.f1v; ifc.fwd1_we = v.f1w;
        ifc.fwd1_is_load = v.f1l; ifc.fwd1_rd = v.f1rd; ifc.fwd1_data = v.f1d;
        ifc.fwd2_valid = v.f2v; ifc.fwd2_we = v.f2w; ifc.fwd2_rd = v.f2rd;
        ifc.fwd2_data = v.f2d;
    endtask

    // Plain ADD x3, x1, x2 with the given rs1 value; used by the sequences.
    task automatic drive_add(input logic [31:0] a);
        clear_inputs();
        ifc.in_valid = 1; ifc.in_opcode = 7'b0110011; ifc.in_rs1_addr = 5'd1;
        ifc.in_rs2_addr = 5'd2; ifc.in_rd_addr = 5'd3; ifc.in_rs1_data = a;
        ifc.in_rs2_data = 32'h22;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        //           pc        opc       f3 f7 rs1 rs2 rd d1            d2        imm           f1v f1w f1l f1rd f1d       f2v f2w f2rd f2d     op     a             b             rs2       we ld ill
        vecs[0]  = '{32'h1000, 7'h33, 3'd0, 0, 1, 2, 3, 32'd5,        32'd7,    32'd0,        0, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  4'h0, 32'd5,        32'd7,        32'd7,    1, 0, 0};
        vecs[1]  = '{32'h1004, 7'h33, 3'd0, 1, 1, 2, 3, 32'd10,       32'd3,    32'd0,        0, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  4'h8, 32'd10,       32'd3,        32'd3,    1, 0, 0};
        vecs[2]  = '{32'h1008, 7'h13, 3'd5, 1, 1, 0, 5, 32'h80000000, 32'h11,   32'h404,      0, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  4'hD, 32'h80000000, 32'h404,      32'h0,    1, 0, 0};
        vecs[3]  = '{32'h100C, 7'h13, 3'd0, 1, 2, 0, 6, 32'd100,      32'd0,    32'hFFFFFC00, 0, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  4'h0, 32'd100,      32'hFFFFFC00, 32'h0,    1, 0, 0};
        vecs[4]  = '{32'h1010, 7'h13, 3'd0, 0, 4, 0, 7, 32'hCC,       32'd0,    32'd1,        1, 1, 0, 4, 32'hAA,    1, 1, 4, 32'hBB, 4'h0, 32'hAA,       32'd1,        32'h0,    1, 0, 0};
        vecs[5]  = '{32'h1014, 7'h13, 3'd0, 0, 4, 0, 7, 32'hCC,       32'd0,    32'd1,        0, 1, 0, 4, 32'hAA,    1, 1, 4, 32'hBB, 4'h0, 32'hBB,       32'd1,        32'h0,    1, 0, 0};
        vecs[6]  = '{32'h1018, 7'h13, 3'd0, 0, 0, 0, 7, 32'hCC,       32'd0,    32'd1,        1, 1, 0, 0, 32'hAA,    1, 1, 0, 32'hBB, 4'h0, 32'h0,        32'd1,        32'h0,    1, 0, 0};
        vecs[7]  = '{32'h1020, 7'h37, 3'd0, 0, 6, 0, 8, 32'h1234,     32'd0,    32'h12345000, 1, 1, 1, 6, 32'hDEAD,  0, 0, 0, 32'h0,  4'h0, 32'h0,        32'h12345000, 32'h0,    1, 0, 0};
        vecs[8]  = '{32'h0100, 7'h17, 3'd0, 0, 0, 0, 9, 32'd0,        32'd0,    32'h2000,     0, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  4'h0, 32'h100,      32'h2000,     32'h0,    1, 0, 0};
        vecs[9]  = '{32'h0200, 7'h6F, 3'd0, 0, 0, 0, 1, 32'd0,        32'd0,    32'h40,       0, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  4'h0, 32'h200,      32'd4,        32'h0,    1, 0, 0};
        vecs[10] = '{32'h0300, 7'h67, 3'd0, 0, 5, 0, 1, 32'h999,      32'd0,    32'h10,       0, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  4'h0, 32'h300,      32'd4,        32'h0,    1, 0, 0};
        vecs[11] = '{32'h0304, 7'h63, 3'd1, 0, 1, 2, 10, 32'd1,       32'd2,    32'h20,       0, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  4'h8, 32'd1,        32'd2,        32'd2,    0, 0, 0};
        vecs[12] = '{32'h0308, 7'h23, 3'd2, 0, 3, 4, 5, 32'h1000,     32'h55,   32'd8,        0, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  4'h0, 32'h1000,     32'd8,        32'h55,   0, 0, 0};
        vecs[13] = '{32'h030C, 7'h03, 3'd2, 0, 3, 0, 5, 32'h2000,     32'd0,    32'hFFFFFFFC, 0, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  4'h0, 32'h2000,     32'hFFFFFFFC, 32'h0,    1, 1, 0};
        vecs[14] = '{32'h0310, 7'h7F, 3'd0, 0, 1, 2, 3, 32'd5,        32'd7,    32'h30,       0, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  4'h0, 32'h0,        32'h0,        32'd7,    0, 0, 1};
        vecs[15] = '{32'h0314, 7'h33, 3'd7, 0, 1, 2, 0, 32'hF0,       32'h3C,   32'd0,        0, 0, 0, 0, 32'h0,     0, 0, 0, 32'h0,  4'h7, 32'hF0,       32'h3C,       32'h3C,   0, 0, 0};
        vecs[16] = '{32'h0318, 7'h33, 3'd4, 0, 1, 9, 3, 32'd1,        32'h777,  32'd0,        0, 0, 0, 0, 32'h0,     1, 1, 9, 32'h99, 4'h4, 32'd1,        32'h99,       32'h99,   1, 0, 0};
        vecs[17] = '{32'h031C, 7'h33, 3'd4, 0, 1, 9, 3, 32'd1,        32'h777,  32'd0,        1, 0, 0, 9, 32'h5,     0, 0, 0, 32'h0,  4'h4, 32'd1,        32'h777,      32'h777,  1, 0, 0};

        clear_inputs();
        ifc.out_ready = 1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(ifc.out_valid), 32'd0);
        chk("reset out_alu_a", ifc.out_alu_a, 32'd0);
        chk("reset out_pc", ifc.out_pc, 32'd0);
        chk("reset in_ready", 32'(ifc.in_ready), 32'd1);
        rst_n = 1;
        step();

        for (int i = 0; i < 18; i++) begin
            drive_vec(vecs[i]);
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(ifc.in_ready), 32'd1);
            step();
            chk($sformatf("v%0d out_valid", i), 32'(ifc.out_valid), 32'd1);
            chk($sformatf("v%0d alu_op", i), 32'(ifc.out_alu_op), 32'(vecs[i].e_op));
            chk($sformatf("v%0d alu_a", i), ifc.out_alu_a, vecs[i].e_a);
            chk($sformatf("v%0d alu_b", i), ifc.out_alu_b, vecs[i].e_b);
            chk($sformatf("v%0d rs2_data", i), ifc.out_rs2_data, vecs[i].e_rs2);
            chk($sformatf("v%0d pc", i), ifc.out_pc, vecs[i].pc);
            chk($sformatf("v%0d funct3", i), 32'(ifc.out_funct3), 32'(vecs[i].f3));
            chk($sformatf("v%0d rd_addr", i), 32'(ifc.out_rd_addr), 32'(vecs[i].rd));
            chk($sformatf("v%0d rd_we", i), 32'(ifc.out_rd_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d is_load", i), 32'(ifc.out_is_load), 32'(vecs[i].e_ld));
            chk($sformatf("v%0d illegal", i), 32'(ifc.out_illegal), 32'(vecs[i].e_ill));
        end
        clear_inputs();
        step();
        chk("bubble out_valid", 32'(ifc.out_valid), 32'd0);

        // Load-use: EX holds a load to x6, incoming ADD reads x6.
        drive_add(32'h11);
        step();
        drive_add(32'h66);
        ifc.in_rs1_addr = 5'd6;
        ifc.fwd1_valid = 1; ifc.fwd1_we = 1; ifc.fwd1_is_load = 1;
        ifc.fwd1_rd = 5'd6; ifc.fwd1_data = 32'hBAD;
        #1;
        chk("lu in_ready", 32'(ifc.in_ready), 32'd0);
        step();
        chk("lu out_valid drop", 32'(ifc.out_valid), 32'd0);
        chk("lu in_ready held", 32'(ifc.in_ready), 32'd0);
        ifc.fwd1_valid = 0;
        #1;
        chk("lu in_ready release", 32'(ifc.in_ready), 32'd1);
        step();
        chk("lu issue valid", 32'(ifc.out_valid), 32'd1);
        chk("lu issue alu_a", ifc.out_alu_a, 32'h66);

        // Backpressure for three cycles, then resume.
        drive_add(32'h1111);
        step();
        drive_add(32'h3333);
        ifc.out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d in_ready", k), 32'(ifc.in_ready), 32'd0);
            chk($sformatf("bp%0d out_valid", k), 32'(ifc.out_valid), 32'd1);
            chk($sformatf("bp%0d alu_a", k), ifc.out_alu_a, 32'h1111);
            step();
        end
        ifc.out_ready = 1;
        #1;
        chk("bp resume in_ready", 32'(ifc.in_ready), 32'd1);
        step();
        chk("bp resume valid", 32'(ifc.out_valid), 32'd1);
        chk("bp resume alu_a", ifc.out_alu_a, 32'h3333);
        clear_inputs();
        step();
        chk("bp drain valid", 32'(ifc.out_valid), 32'd0);

        // Flush with a held instruction and a new one arriving.
        drive_add(32'h44);
        step();
        drive_add(32'h55);
        ifc.flush = 1;
        ifc.out_ready = 0;
        #1;
        chk("flush in_ready", 32'(ifc.in_ready), 32'd1);
        step();
        chk("flush out_valid", 32'(ifc.out_valid), 32'd0);
        clear_inputs();
        ifc.out_ready = 1;

        // Asynchronous reset between clock edges.
        drive_add(32'h77);
        step();
        chk("prerst out_valid", 32'(ifc.out_valid), 32'd1);
        clear_inputs();
        #2;
        rst_n = 0;
        #1;
        chk("async rst out_valid", 32'(ifc.out_valid), 32'd0);
        chk("async rst alu_a", ifc.out_alu_a, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        step();
        chk("post rst out_valid", 32'(ifc.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
